// File: rtl/xif_coproc_router.sv
// rtl/xif_coproc_router.sv - shares one CORE-V-XIF offload port between two coprocessors
//
// Purpose:
//   Broadcasts core issue requests to CP0 (FPU) and CP1 (spare), records the
//   accepting coprocessor per instruction ID, steers commit/kill to the owner,
//   and round-robin arbitrates coprocessor results back to the core.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   x_issue_*                         core-side issue channel
//   cp_issue_instr_o/cp_issue_id_o    issue payload broadcast to both coprocessors
//   cp{0,1}_issue_*                   per-coprocessor issue handshake and response
//   x_commit_*                        core-side commit channel
//   cp_commit_id_o, cp{0,1}_commit_*  commit broadcast, per-coprocessor kill
//   cp{0,1}_result_*                  coprocessor result channels
//   x_result_*                        arbitrated result channel to the core
//   err_o                             sticky protocol error (bad result ID/owner)
//   perf_cp{0,1}_cnt_o                accepted-issue counters per owner
//                                     (present only with XIF_ROUTER_PERF_EN)

module xif_coproc_router #(
  parameter int IdWidth   = 4,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 x_issue_valid_i,
  output logic                 x_issue_ready_o,
  input  logic [31:0]          x_issue_instr_i,
  input  logic [IdWidth-1:0]   x_issue_id_i,
  output logic                 x_issue_accept_o,
  output logic                 x_issue_writeback_o,
  output logic [31:0]          cp_issue_instr_o,
  output logic [IdWidth-1:0]   cp_issue_id_o,
  output logic                 cp0_issue_valid_o,
  output logic                 cp1_issue_valid_o,
  input  logic                 cp0_issue_ready_i,
  input  logic                 cp1_issue_ready_i,
  input  logic                 cp0_issue_accept_i,
  input  logic                 cp1_issue_accept_i,
  input  logic                 cp0_issue_wb_i,
  input  logic                 cp1_issue_wb_i,
  input  logic                 x_commit_valid_i,
  input  logic [IdWidth-1:0]   x_commit_id_i,
  input  logic                 x_commit_kill_i,
  output logic [IdWidth-1:0]   cp_commit_id_o,
  output logic                 cp0_commit_valid_o,
  output logic                 cp1_commit_valid_o,
  output logic                 cp0_commit_kill_o,
  output logic                 cp1_commit_kill_o,
  input  logic                 cp0_result_valid_i,
  input  logic                 cp1_result_valid_i,
  output logic                 cp0_result_ready_o,
  output logic                 cp1_result_ready_o,
  input  logic [IdWidth-1:0]   cp0_result_id_i,
  input  logic [IdWidth-1:0]   cp1_result_id_i,
  input  logic [DataWidth-1:0] cp0_result_data_i,
  input  logic [DataWidth-1:0] cp1_result_data_i,
  input  logic                 cp0_result_we_i,
  input  logic                 cp1_result_we_i,
  output logic                 x_result_valid_o,
  input  logic                 x_result_ready_i,
  output logic [IdWidth-1:0]   x_result_id_o,
  output logic [DataWidth-1:0] x_result_data_o,
  output logic                 x_result_we_o,
  output logic                 err_o
`ifdef XIF_ROUTER_PERF_EN
  ,
  output logic [31:0]          perf_cp0_cnt_o,
  output logic [31:0]          perf_cp1_cnt_o
`endif
);

  localparam int NumIds = 2 ** IdWidth;

  // ID table: valid bit and owner (0 = CP0, 1 = CP1) per instruction ID
  logic [NumIds-1:0] tbl_valid;
  logic [NumIds-1:0] tbl_owner;

  logic [1:0] seen_q, acc_q, wb_q;
  logic       rr_q, lock_q, gnt_q, err_q;

  logic [1:0] issue_vld, cp_ready, cp_acc, cp_wb, eff_acc, eff_wb;
  logic       stall, issue_go, accepted, owner;
  logic       cm_valid, cm_owner;
  logic [1:0] rvld, bad, cand;
  logic       grant, res_hs;
  logic [IdWidth-1:0] res_id;

  assign stall  = tbl_valid[x_issue_id_i];
  assign cp_acc = {cp1_issue_accept_i, cp0_issue_accept_i};
  assign cp_wb  = {cp1_issue_wb_i, cp0_issue_wb_i};

  always_comb begin
    // A coprocessor that already answered this instruction is not asked again
    issue_vld = {2{x_issue_valid_i & ~stall & ~rst_i}} & ~seen_q;
    cp_ready  = issue_vld & {cp1_issue_ready_i, cp0_issue_ready_i};
    issue_go  = x_issue_valid_i & ~stall & ~rst_i & (&(seen_q | cp_ready));
    eff_acc   = (seen_q & acc_q) | (~seen_q & cp_acc);
    eff_wb    = (seen_q & wb_q) | (~seen_q & cp_wb);
    accepted  = |eff_acc;
    owner     = ~eff_acc[0];  // CP0 wins when both accept
  end

  assign x_issue_ready_o     = issue_go;
  assign x_issue_accept_o    = accepted;
  assign x_issue_writeback_o = owner ? eff_wb[1] : eff_wb[0];
  assign cp_issue_instr_o    = x_issue_instr_i;
  assign cp_issue_id_o       = x_issue_id_i;
  assign cp0_issue_valid_o   = issue_vld[0];
  assign cp1_issue_valid_o   = issue_vld[1];

  assign cm_valid           = tbl_valid[x_commit_id_i];
  assign cm_owner           = tbl_owner[x_commit_id_i];
  assign cp_commit_id_o     = x_commit_id_i;
  assign cp0_commit_valid_o = x_commit_valid_i & ~rst_i;
  assign cp1_commit_valid_o = x_commit_valid_i & ~rst_i;
  assign cp0_commit_kill_o  = x_commit_kill_i | ~(cm_valid & ~cm_owner);
  assign cp1_commit_kill_o  = x_commit_kill_i | ~(cm_valid & cm_owner);

  always_comb begin
    rvld   = {cp1_result_valid_i, cp0_result_valid_i} & {2{~rst_i}};
    // Results for unknown IDs or from the wrong coprocessor are drained and dropped
    bad[0] = rvld[0] & ~(tbl_valid[cp0_result_id_i] & ~tbl_owner[cp0_result_id_i]);
    bad[1] = rvld[1] & ~(tbl_valid[cp1_result_id_i] & tbl_owner[cp1_result_id_i]);
    cand   = rvld & ~bad;
    if (lock_q)        grant = gnt_q;
    else if (&cand)    grant = ~rr_q;
    else               grant = cand[1];
    res_id = grant ? cp1_result_id_i : cp0_result_id_i;
  end

  assign x_result_valid_o   = cand[grant];
  assign x_result_id_o      = res_id;
  assign x_result_data_o    = grant ? cp1_result_data_i : cp0_result_data_i;
  assign x_result_we_o      = grant ? cp1_result_we_i : cp0_result_we_i;
  assign res_hs             = x_result_valid_o & x_result_ready_i;
  assign cp0_result_ready_o = bad[0] | (~grant & cand[0] & x_result_ready_i);
  assign cp1_result_ready_o = bad[1] | (grant & cand[1] & x_result_ready_i);
  assign err_o              = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl_valid <= '0;
      tbl_owner <= '0;
      seen_q    <= 2'b00;
      acc_q     <= 2'b00;
      wb_q      <= 2'b00;
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      gnt_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_q <= (cp_ready & cp_acc) | (~cp_ready & acc_q);
      wb_q  <= (cp_ready & cp_wb) | (~cp_ready & wb_q);
      if (x_commit_valid_i && x_commit_kill_i) tbl_valid[x_commit_id_i] <= 1'b0;
      if (res_hs) begin
        tbl_valid[res_id] <= 1'b0;
        rr_q              <= grant;
      end
      // Freeze the grant while the core back-pressures a presented result
      lock_q <= x_result_valid_o & ~x_result_ready_i;
      gnt_q  <= grant;
      if (|bad) err_q <= 1'b1;
      if (issue_go) begin
        seen_q <= 2'b00;
        if (accepted) begin
          tbl_valid[x_issue_id_i] <= 1'b1;
          tbl_owner[x_issue_id_i] <= owner;
        end
      end else begin
        seen_q <= seen_q | cp_ready;
      end
    end
  end

`ifdef XIF_ROUTER_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cp0_cnt_o <= '0;
      perf_cp1_cnt_o <= '0;
    end else if (issue_go && accepted) begin
      if (owner) perf_cp1_cnt_o <= perf_cp1_cnt_o + 32'd1;
      else       perf_cp0_cnt_o <= perf_cp0_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xif_coproc_router.sv
// tb/tb_xif_coproc_router.sv - self-checking bench for xif_coproc_router

module tb_xif_coproc_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_issue_valid = 1'b0;
  logic        x_issue_ready;
  logic [31:0] x_issue_instr = 32'h0;
  logic [3:0]  x_issue_id = 4'h0;
  logic        x_issue_accept, x_issue_writeback;
  logic [31:0] cp_issue_instr;
  logic [3:0]  cp_issue_id;
  logic        cp0_issue_valid, cp1_issue_valid;
  logic        cp0_issue_ready = 1'b0, cp1_issue_ready = 1'b0;
  logic        cp0_issue_accept = 1'b0, cp1_issue_accept = 1'b0;
  logic        cp0_issue_wb = 1'b0, cp1_issue_wb = 1'b0;
  logic        x_commit_valid = 1'b0;
  logic [3:0]  x_commit_id = 4'h0;
  logic        x_commit_kill = 1'b0;
  logic [3:0]  cp_commit_id;
  logic        cp0_commit_valid, cp1_commit_valid, cp0_commit_kill, cp1_commit_kill;
  logic        cp0_result_valid = 1'b0, cp1_result_valid = 1'b0;
  logic        cp0_result_ready, cp1_result_ready;
  logic [3:0]  cp0_result_id = 4'h0, cp1_result_id = 4'h0;
  logic [31:0] cp0_result_data = 32'h0, cp1_result_data = 32'h0;
  logic        cp0_result_we = 1'b0, cp1_result_we = 1'b0;
  logic        x_result_valid;
  logic        x_result_ready = 1'b0;
  logic [3:0]  x_result_id;
  logic [31:0] x_result_data;
  logic        x_result_we, err;

  int vectors = 0;
  int miscompares = 0;
  logic [36:0] sb[$];  // {we, id, data}

  xif_coproc_router #(.IdWidth(4), .DataWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .x_issue_valid_i(x_issue_valid), .x_issue_ready_o(x_issue_ready),
    .x_issue_instr_i(x_issue_instr), .x_issue_id_i(x_issue_id),
    .x_issue_accept_o(x_issue_accept), .x_issue_writeback_o(x_issue_writeback),
    .cp_issue_instr_o(cp_issue_instr), .cp_issue_id_o(cp_issue_id),
    .cp0_issue_valid_o(cp0_issue_valid), .cp1_issue_valid_o(cp1_issue_valid),
    .cp0_issue_ready_i(cp0_issue_ready), .cp1_issue_ready_i(cp1_issue_ready),
    .cp0_issue_accept_i(cp0_issue_accept), .cp1_issue_accept_i(cp1_issue_accept),
    .cp0_issue_wb_i(cp0_issue_wb), .cp1_issue_wb_i(cp1_issue_wb),
    .x_commit_valid_i(x_commit_valid), .x_commit_id_i(x_commit_id),
    .x_commit_kill_i(x_commit_kill), .cp_commit_id_o(cp_commit_id),
    .cp0_commit_valid_o(cp0_commit_valid), .cp1_commit_valid_o(cp1_commit_valid),
    .cp0_commit_kill_o(cp0_commit_kill), .cp1_commit_kill_o(cp1_commit_kill),
    .cp0_result_valid_i(cp0_result_valid), .cp1_result_valid_i(cp1_result_valid),
    .cp0_result_ready_o(cp0_result_ready), .cp1_result_ready_o(cp1_result_ready),
    .cp0_result_id_i(cp0_result_id), .cp1_result_id_i(cp1_result_id),
    .cp0_result_data_i(cp0_result_data), .cp1_result_data_i(cp1_result_data),
    .cp0_result_we_i(cp0_result_we), .cp1_result_we_i(cp1_result_we),
    .x_result_valid_o(x_result_valid), .x_result_ready_i(x_result_ready),
    .x_result_id_o(x_result_id), .x_result_data_o(x_result_data),
    .x_result_we_o(x_result_we), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_issue();
    x_issue_valid = 1'b0;
    cp0_issue_ready = 1'b0; cp0_issue_accept = 1'b0; cp0_issue_wb = 1'b0;
    cp1_issue_ready = 1'b0; cp1_issue_accept = 1'b0; cp1_issue_wb = 1'b0;
  endtask

  // Single-cycle issue with both coprocessors answering at once
  task automatic do_issue(input string tag, input logic [3:0] id,
                          input logic a0, input logic a1, input logic exp_ready);
    x_issue_valid = 1'b1; x_issue_id = id;
    cp0_issue_ready = 1'b1; cp0_issue_accept = a0; cp0_issue_wb = 1'b1;
    cp1_issue_ready = 1'b1; cp1_issue_accept = a1; cp1_issue_wb = 1'b1;
    #1;
    check(tag, x_issue_ready, exp_ready);
    tick();
    clear_issue();
  endtask

  // Scoreboard: every core-side result handshake pops one expected entry
  always @(negedge clk) begin
    if (!rst && x_result_valid && x_result_ready) begin
      if (sb.size() == 0) check("sb_unexpected", 1, 0);
      else check("result", {x_result_we, x_result_id, x_result_data}, sb.pop_front());
    end
  end

  initial begin
    // Reset: outputs held low even with active inputs
    x_issue_valid = 1'b1; cp0_issue_ready = 1'b1; cp1_issue_ready = 1'b1;
    cp0_result_valid = 1'b1; x_result_ready = 1'b1; x_commit_valid = 1'b1;
    #1;
    check("rst_issue_ready", x_issue_ready, 0);
    check("rst_cp0_issue_valid", cp0_issue_valid, 0);
    check("rst_result_valid", x_result_valid, 0);
    check("rst_cp0_result_ready", cp0_result_ready, 0);
    check("rst_commit_valid", cp0_commit_valid, 0);
    check("rst_err", err, 0);
    tick(); tick();
    clear_issue(); cp0_result_valid = 1'b0; x_result_ready = 1'b0; x_commit_valid = 1'b0;
    rst = 1'b0;
    tick();

    // T1: same-cycle completion, CP0 owns id 3
    x_issue_valid = 1'b1; x_issue_id = 4'd3; x_issue_instr = 32'hABCD0053;
    cp0_issue_ready = 1'b1; cp0_issue_accept = 1'b1; cp0_issue_wb = 1'b1;
    cp1_issue_ready = 1'b1;
    #1;
    check("t1_cp0_valid", cp0_issue_valid, 1);
    check("t1_instr_bcast", cp_issue_instr, 32'hABCD0053);
    check("t1_ready", x_issue_ready, 1);
    check("t1_accept", x_issue_accept, 1);
    check("t1_wb", x_issue_writeback, 1);
    tick(); clear_issue();

    // T2: commit routed to owner, then result forwarded and entry freed
    x_commit_valid = 1'b1; x_commit_id = 4'd3; x_commit_kill = 1'b0;
    #1;
    check("t2_cp0_kill", cp0_commit_kill, 0);
    check("t2_cp1_kill", cp1_commit_kill, 1);
    check("t2_commit_valid", cp1_commit_valid, 1);
    tick(); x_commit_valid = 1'b0;
    cp0_result_valid = 1'b1; cp0_result_id = 4'd3; cp0_result_data = 32'h3F800000;
    cp0_result_we = 1'b1; x_result_ready = 1'b1;
    sb.push_back({1'b1, 4'd3, 32'h3F800000});
    #1;
    check("t2_res_valid", x_result_valid, 1);
    check("t2_cp0_res_ready", cp0_result_ready, 1);
    tick(); cp0_result_valid = 1'b0; x_result_ready = 1'b0;
    #1;
    check("t2_freed_kill0", cp0_commit_kill, 1);

    // Two-phase issue of id 4: CP0 declines first, CP1 accepts later
    x_issue_valid = 1'b1; x_issue_id = 4'd4; cp0_issue_ready = 1'b1;
    #1;
    check("p1_ready", x_issue_ready, 0);
    check("p1_cp1_valid", cp1_issue_valid, 1);
    tick();
    cp0_issue_ready = 1'b0; cp1_issue_ready = 1'b1; cp1_issue_accept = 1'b1; cp1_issue_wb = 1'b1;
    #1;
    check("p2_cp0_valid", cp0_issue_valid, 0);
    check("p2_ready", x_issue_ready, 1);
    check("p2_accept", x_issue_accept, 1);
    check("p2_wb", x_issue_writeback, 1);
    tick(); clear_issue();
    x_commit_id = 4'd4; #1;
    check("p_kill0", cp0_commit_kill, 1);
    check("p_kill1", cp1_commit_kill, 0);

    // Both accept id 1 -> CP0 owns; id 6 owned by CP1
    do_issue("both_acc_ready", 4'd1, 1'b1, 1'b1, 1'b1);
    x_commit_id = 4'd1; #1;
    check("both_acc_kill0", cp0_commit_kill, 0);
    check("both_acc_kill1", cp1_commit_kill, 1);
    do_issue("id6_ready", 4'd6, 1'b0, 1'b1, 1'b1);

    // T3: both results pending, core stalls 3 cycles; rr_q=CP0 so CP1 first
    cp0_result_valid = 1'b1; cp0_result_id = 4'd1; cp0_result_data = 32'h11111111; cp0_result_we = 1'b1;
    cp1_result_valid = 1'b1; cp1_result_id = 4'd4; cp1_result_data = 32'h44444444; cp1_result_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_hold_id", x_result_id, 4'd4);
      check("t3_hold_data", x_result_data, 32'h44444444);
      check("t3_hold_rdy", {cp1_result_ready, cp0_result_ready}, 2'b00);
      tick();
    end
    x_result_ready = 1'b1;
    sb.push_back({1'b0, 4'd4, 32'h44444444});
    #1;
    check("t3_cp1_ready", cp1_result_ready, 1);
    tick();
    cp1_result_id = 4'd6; cp1_result_data = 32'h66666666; cp1_result_we = 1'b1;
    #1;
    check("t3_rr_next", x_result_id, 4'd1);
    sb.push_back({1'b1, 4'd1, 32'h11111111});
    tick(); cp0_result_valid = 1'b0;
    #1;
    check("t3_last", x_result_id, 4'd6);
    sb.push_back({1'b1, 4'd6, 32'h66666666});
    tick(); cp1_result_valid = 1'b0; x_result_ready = 1'b0;

    // T4: reissue of a live ID stalls until the cycle after its kill
    do_issue("t4_first", 4'd5, 1'b1, 1'b0, 1'b1);
    x_issue_valid = 1'b1; x_issue_id = 4'd5; cp0_issue_ready = 1'b1; cp1_issue_ready = 1'b1;
    #1;
    check("t4_stall_valid", {cp1_issue_valid, cp0_issue_valid}, 2'b00);
    check("t4_stall_ready", x_issue_ready, 0);
    tick();
    x_commit_valid = 1'b1; x_commit_id = 4'd5; x_commit_kill = 1'b1;
    #1;
    check("t4_kill_cycle_ready", x_issue_ready, 0);
    check("t4_kill0", cp0_commit_kill, 1);
    tick(); x_commit_valid = 1'b0; x_commit_kill = 1'b0;
    #1;
    check("t4_go_ready", x_issue_ready, 1);
    check("t4_no_accept", x_issue_accept, 0);
    tick(); clear_issue();
    #1;
    check("t4_no_entry", {cp1_commit_kill, cp0_commit_kill}, 2'b11);

    // T5: CP1 result for a CP0-owned ID is drained and flagged
    check("t5_err_before", err, 0);
    do_issue("t5_issue", 4'd7, 1'b1, 1'b0, 1'b1);
    cp1_result_valid = 1'b1; cp1_result_id = 4'd7; cp1_result_data = 32'hDEADBEEF;
    #1;
    check("t5_cp1_ready", cp1_result_ready, 1);
    check("t5_no_fwd", x_result_valid, 0);
    tick(); cp1_result_valid = 1'b0;
    #1;
    check("t5_err", err, 1);
    tick(); tick();
    check("t5_err_held", err, 1);

    // T6: reset during a stalled result
    cp0_result_valid = 1'b1; cp0_result_id = 4'd7; cp0_result_data = 32'h77777777;
    tick(); tick();
    check("t6_stalled", x_result_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_res_valid", x_result_valid, 0);
    check("t6_rst_res_ready", cp0_result_ready, 0);
    tick();
    rst = 1'b0; cp0_result_valid = 1'b0;
    x_commit_id = 4'd7;
    #1;
    check("t6_err_clr", err, 0);
    check("t6_tbl_empty", {cp1_commit_kill, cp0_commit_kill}, 2'b11);
    do_issue("t6_id5_nostall", 4'd5, 1'b1, 1'b0, 1'b1);

    tick();
    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
